// File: rtl/svs_monitor_pkg.sv
// Shared constants and state encoding for the SVS ring-oscillator monitor sequencer.
package svs_monitor_pkg;

  localparam int unsigned SVS_NB_MONITOR    = 30;
  localparam int unsigned SVS_COUNT_W       = 16;
  localparam int unsigned SVS_TARGET_W      = 3;
  localparam int unsigned SVS_WINDOW_W      = 16;
  localparam int unsigned SVS_SETTLE_CYCLES = 4;
  localparam int unsigned SVS_MEAS_CNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE,
    SCAN,
    DONE
  } svs_ctrl_state_e;

endpackage

// File: rtl/svs_monitor_scan.sv
// Walks the captured monitor counts one per step, staging lo/hi flags and the minimum.
// Staged results are exposed combinationally so the final step can be committed on the same edge.
module svs_monitor_scan
  import svs_monitor_pkg::*;
#(
  parameter int unsigned NbMonitor = SVS_NB_MONITOR,
  parameter int unsigned CountW    = SVS_COUNT_W,
  parameter int unsigned IdxW      = (NbMonitor > 1) ? $clog2(NbMonitor) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_init,
  input  logic                        i_step,
  input  logic [CountW-1:0]           i_thr_lo,
  input  logic [CountW-1:0]           i_thr_hi,
  input  logic [NbMonitor-1:0]        i_mask,
  input  logic [NbMonitor*CountW-1:0] i_mon_count,
  output logic                        o_last_c,
  output logic [CountW-1:0]           o_min_count_c,
  output logic [IdxW-1:0]             o_min_idx_c,
  output logic [NbMonitor-1:0]        o_lo_flags_c,
  output logic [NbMonitor-1:0]        o_hi_flags_c
);

  logic [IdxW-1:0]      idx_q, idx_d;
  logic [CountW-1:0]    min_q, min_d;
  logic [IdxW-1:0]      min_idx_q, min_idx_d;
  logic [NbMonitor-1:0] lo_q, lo_d;
  logic [NbMonitor-1:0] hi_q, hi_d;
  logic [CountW-1:0]    cur;

  assign o_last_c = (idx_q == IdxW'(NbMonitor - 1));

  always_comb begin
    idx_d     = idx_q;
    min_d     = min_q;
    min_idx_d = min_idx_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    cur       = i_mon_count[int'(idx_q)*CountW +: CountW];
    if (i_init) begin
      idx_d     = '0;
      min_d     = '1;
      min_idx_d = '0;
      lo_d      = '0;
      hi_d      = '0;
    end else if (i_step) begin
      // Masked monitors still consume their slot but leave results untouched
      if (!i_mask[idx_q]) begin
        if (cur < i_thr_lo) lo_d[idx_q] = 1'b1;
        if (cur > i_thr_hi) hi_d[idx_q] = 1'b1;
        if (cur < min_q) begin
          min_d     = cur;
          min_idx_d = idx_q;
        end
      end
      idx_d = o_last_c ? '0 : idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_q     <= '0;
      min_q     <= '1;
      min_idx_q <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      idx_q     <= idx_d;
      min_q     <= min_d;
      min_idx_q <= min_idx_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
    end
  end

  assign o_min_count_c = min_d;
  assign o_min_idx_c   = min_idx_d;
  assign o_lo_flags_c  = lo_d;
  assign o_hi_flags_c  = hi_d;

endmodule

// File: rtl/svs_monitor_ctrl.sv
// SVS measurement sequencer: clear, gate monitors for a window, settle, scan, report.
// Control outputs are registered from the next state so they line up with the state they describe.
module svs_monitor_ctrl
  import svs_monitor_pkg::*;
#(
  parameter int unsigned NbMonitor    = SVS_NB_MONITOR,
  parameter int unsigned CountW       = SVS_COUNT_W,
  parameter int unsigned TargetW      = SVS_TARGET_W,
  parameter int unsigned WindowW      = SVS_WINDOW_W,
  parameter int unsigned SettleCycles = SVS_SETTLE_CYCLES,
  parameter int unsigned IdxW         = (NbMonitor > 1) ? $clog2(NbMonitor) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic                        i_stop,
  input  logic                        i_cont,
  input  logic [TargetW-1:0]          i_target,
  input  logic [WindowW-1:0]          i_window,
  input  logic [CountW-1:0]           i_thr_lo,
  input  logic [CountW-1:0]           i_thr_hi,
  input  logic [NbMonitor-1:0]        i_mask,
  input  logic [NbMonitor*CountW-1:0] i_mon_count,
  output logic                        o_mon_clear,
  output logic                        o_mon_en,
  output logic [TargetW-1:0]          o_mon_target,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [CountW-1:0]           o_min_count,
  output logic [IdxW-1:0]             o_min_idx,
  output logic [NbMonitor-1:0]        o_lo_flags,
  output logic [NbMonitor-1:0]        o_hi_flags,
  output logic                        o_alarm,
  output logic [15:0]                 o_meas_cnt
);

  localparam int unsigned MeasW   = SVS_MEAS_CNT_W;
  localparam int unsigned SettleW = $clog2(SettleCycles + 1);
  localparam int unsigned CntW    = (WindowW > SettleW) ? WindowW : SettleW;

  svs_ctrl_state_e      state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 cont_q, cont_d;
  logic [WindowW-1:0]   window_q, window_d;
  logic [CountW-1:0]    thr_lo_q, thr_lo_d;
  logic [CountW-1:0]    thr_hi_q, thr_hi_d;
  logic [NbMonitor-1:0] mask_q, mask_d;
  logic [TargetW-1:0]   target_q, target_d;

  logic                 mon_clear_q, mon_clear_d;
  logic                 mon_en_q, mon_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CountW-1:0]    min_count_q, min_count_d;
  logic [IdxW-1:0]      min_idx_q, min_idx_d;
  logic [NbMonitor-1:0] lo_flags_q, lo_flags_d;
  logic [NbMonitor-1:0] hi_flags_q, hi_flags_d;
  logic                 alarm_q, alarm_d;
  logic [MeasW-1:0]     meas_cnt_q, meas_cnt_d;

  logic                 scan_init, scan_step, scan_last;
  logic [CountW-1:0]    scan_min;
  logic [IdxW-1:0]      scan_idx;
  logic [NbMonitor-1:0] scan_lo, scan_hi;
  logic [CntW-1:0]      run_load;

  // A zero window still runs the monitors for one cycle
  assign run_load = (window_q == '0) ? '0 : CntW'(window_q - WindowW'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cont_d    = cont_q;
    window_d  = window_q;
    thr_lo_d  = thr_lo_q;
    thr_hi_d  = thr_hi_q;
    mask_d    = mask_q;
    target_d  = target_q;
    scan_init = 1'b0;
    scan_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && !i_stop) begin
          cont_d   = i_cont;
          window_d = i_window;
          thr_lo_d = i_thr_lo;
          thr_hi_d = i_thr_hi;
          mask_d   = i_mask;
          target_d = i_target;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        scan_init = 1'b1;
        cnt_d     = run_load;
        state_d   = RUN;
      end
      RUN: begin
        if (cnt_q == '0) begin
          cnt_d   = CntW'(SettleCycles - 1);
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = SCAN;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      SCAN: begin
        scan_step = 1'b1;
        if (scan_last) state_d = DONE;
      end
      DONE:    state_d = (cont_q && !i_stop) ? CLEAR : IDLE;
      default: state_d = IDLE;
    endcase
    if (i_stop && (state_q inside {CLEAR, RUN, SETTLE, SCAN})) state_d = IDLE;
  end

  // Output staging: results and the measurement counter move only on entry to DONE
  always_comb begin
    mon_clear_d = (state_d == CLEAR);
    mon_en_d    = (state_d == RUN);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    min_count_d = min_count_q;
    min_idx_d   = min_idx_q;
    lo_flags_d  = lo_flags_q;
    hi_flags_d  = hi_flags_q;
    alarm_d     = alarm_q;
    meas_cnt_d  = meas_cnt_q;
    if (state_d == DONE) begin
      min_count_d = scan_min;
      min_idx_d   = scan_idx;
      lo_flags_d  = scan_lo;
      hi_flags_d  = scan_hi;
      alarm_d     = |(scan_lo | scan_hi);
      meas_cnt_d  = meas_cnt_q + MeasW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cont_q      <= 1'b0;
      window_q    <= '0;
      thr_lo_q    <= '0;
      thr_hi_q    <= '0;
      mask_q      <= '0;
      target_q    <= '0;
      mon_clear_q <= 1'b0;
      mon_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      min_count_q <= '0;
      min_idx_q   <= '0;
      lo_flags_q  <= '0;
      hi_flags_q  <= '0;
      alarm_q     <= 1'b0;
      meas_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cont_q      <= cont_d;
      window_q    <= window_d;
      thr_lo_q    <= thr_lo_d;
      thr_hi_q    <= thr_hi_d;
      mask_q      <= mask_d;
      target_q    <= target_d;
      mon_clear_q <= mon_clear_d;
      mon_en_q    <= mon_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      min_count_q <= min_count_d;
      min_idx_q   <= min_idx_d;
      lo_flags_q  <= lo_flags_d;
      hi_flags_q  <= hi_flags_d;
      alarm_q     <= alarm_d;
      meas_cnt_q  <= meas_cnt_d;
    end
  end

  svs_monitor_scan #(
    .NbMonitor (NbMonitor),
    .CountW    (CountW),
    .IdxW      (IdxW)
  ) u_scan (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_init        (scan_init),
    .i_step        (scan_step),
    .i_thr_lo      (thr_lo_q),
    .i_thr_hi      (thr_hi_q),
    .i_mask        (mask_q),
    .i_mon_count   (i_mon_count),
    .o_last_c      (scan_last),
    .o_min_count_c (scan_min),
    .o_min_idx_c   (scan_idx),
    .o_lo_flags_c  (scan_lo),
    .o_hi_flags_c  (scan_hi)
  );

  assign o_mon_clear  = mon_clear_q;
  assign o_mon_en     = mon_en_q;
  assign o_mon_target = target_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_min_count  = min_count_q;
  assign o_min_idx    = min_idx_q;
  assign o_lo_flags   = lo_flags_q;
  assign o_hi_flags   = hi_flags_q;
  assign o_alarm      = alarm_q;
  assign o_meas_cnt   = meas_cnt_q;

endmodule

// File: tb/tb_svs_monitor_ctrl.sv
// Bench for svs_monitor_ctrl: vector table, random measurements against a reference model,
// and directed continuous/stop/reset/wrap sequences.
module tb_svs_monitor_ctrl;

  localparam int NB = 30;
  localparam int CW = 16;
  localparam int S  = 4;
  localparam logic [NB-1:0] ALL = {NB{1'b1}};

  logic             i_clk = 1'b0;
  logic             i_rst, i_start, i_stop, i_cont;
  logic [2:0]       i_target;
  logic [15:0]      i_window, i_thr_lo, i_thr_hi;
  logic [NB-1:0]    i_mask;
  logic [NB*CW-1:0] i_mon_count;
  logic             o_mon_clear, o_mon_en, o_busy, o_done, o_alarm;
  logic [2:0]       o_mon_target;
  logic [15:0]      o_min_count, o_meas_cnt;
  logic [4:0]       o_min_idx;
  logic [NB-1:0]    o_lo_flags, o_hi_flags;

  svs_monitor_ctrl #(
    .NbMonitor(NB), .CountW(CW), .TargetW(3), .WindowW(16), .SettleCycles(S), .IdxW(5)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop), .i_cont(i_cont),
    .i_target(i_target), .i_window(i_window), .i_thr_lo(i_thr_lo), .i_thr_hi(i_thr_hi),
    .i_mask(i_mask), .i_mon_count(i_mon_count), .o_mon_clear(o_mon_clear),
    .o_mon_en(o_mon_en), .o_mon_target(o_mon_target), .o_busy(o_busy), .o_done(o_done),
    .o_min_count(o_min_count), .o_min_idx(o_min_idx), .o_lo_flags(o_lo_flags),
    .o_hi_flags(o_hi_flags), .o_alarm(o_alarm), .o_meas_cnt(o_meas_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  logic [15:0]   cnt [NB];
  logic [15:0]   exp_min;
  int            exp_idx;
  logic [NB-1:0] exp_lo, exp_hi;
  logic [15:0]   exp_meas;

  typedef struct {
    logic [15:0]   window, lo, hi;
    logic [NB-1:0] mask;
    logic [15:0]   base;
    int            ia;
    logic [15:0]   va;
    int            ib;
    logic [15:0]   vb;
    logic [15:0]   e_min;
    int            e_idx;
    logic [NB-1:0] e_lo, e_hi;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pack_counts();
    for (int k = 0; k < NB; k++) i_mon_count[k*CW +: CW] = cnt[k];
  endtask

  task automatic set_counts(input logic [15:0] base, input int ia, input logic [15:0] va,
                            input int ib, input logic [15:0] vb);
    for (int k = 0; k < NB; k++) cnt[k] = base;
    cnt[ia] = va;
    cnt[ib] = vb;
    pack_counts();
  endtask

  // Reference: minimum value over unmasked monitors, then first index holding it
  task automatic model(input logic [15:0] lo, input logic [15:0] hi, input logic [NB-1:0] m);
    int best;
    best = -1;
    exp_lo = '0;
    exp_hi = '0;
    for (int k = 0; k < NB; k++) begin
      if (!m[k]) begin
        exp_lo[k] = (int'(cnt[k]) < int'(lo));
        exp_hi[k] = (int'(cnt[k]) > int'(hi));
        if (best < 0 || int'(cnt[k]) < best) best = int'(cnt[k]);
      end
    end
    exp_min = (best < 0) ? 16'hFFFF : 16'(best);
    exp_idx = 0;
    if (best >= 0) begin
      for (int k = NB - 1; k >= 0; k--) if (!m[k] && int'(cnt[k]) == best) exp_idx = k;
    end
  endtask

  task automatic check_results(input string p);
    check({p, "_min"}, 64'(o_min_count), 64'(exp_min));
    check({p, "_idx"}, 64'(o_min_idx), 64'(exp_idx));
    check({p, "_lo"}, 64'(o_lo_flags), 64'(exp_lo));
    check({p, "_hi"}, 64'(o_hi_flags), 64'(exp_hi));
    check({p, "_alarm"}, 64'(o_alarm), 64'(|(exp_lo | exp_hi)));
  endtask

  task automatic check_zero(input string p);
    check({p, "_clear"}, 64'(o_mon_clear), 0);
    check({p, "_en"}, 64'(o_mon_en), 0);
    check({p, "_target"}, 64'(o_mon_target), 0);
    check({p, "_busy"}, 64'(o_busy), 0);
    check({p, "_done"}, 64'(o_done), 0);
    check({p, "_min"}, 64'(o_min_count), 0);
    check({p, "_idx"}, 64'(o_min_idx), 0);
    check({p, "_flags"}, 64'({o_lo_flags, o_hi_flags, o_alarm}), 0);
    check({p, "_meas"}, 64'(o_meas_cnt), 0);
  endtask

  // Single-shot measurement; inputs are scrambled after start to prove shadowing
  task automatic run_meas(input string p, input logic [15:0] w, input logic [15:0] lo,
                          input logic [15:0] hi, input logic [NB-1:0] m, input logic [2:0] tgt);
    logic [15:0]   pmin;
    logic [4:0]    pidx;
    logic [NB-1:0] plo, phi;
    logic          palm;
    int n, clr_n, en_n, clr_last, en_first, wexp, limit;
    bit moved, busy_bad;
    model(lo, hi, m);
    wexp = (w == 16'd0) ? 1 : int'(w);
    limit = wexp + S + NB + 40;
    pmin = o_min_count; pidx = o_min_idx; plo = o_lo_flags; phi = o_hi_flags; palm = o_alarm;
    clr_n = 0; en_n = 0; clr_last = 0; en_first = 0; moved = 0; busy_bad = 0;
    i_window = w; i_thr_lo = lo; i_thr_hi = hi; i_mask = m; i_target = tgt; i_cont = 1'b0;
    i_start = 1'b1;
    @(negedge i_clk);
    n = 1;
    i_start = 1'b0;
    i_window = 16'($urandom); i_thr_lo = 16'($urandom); i_thr_hi = 16'($urandom);
    i_mask = NB'({$urandom, $urandom}); i_target = 3'($urandom); i_cont = 1'b1;
    while (o_done !== 1'b1 && n < limit) begin
      if (o_mon_clear) begin clr_n++; clr_last = n; end
      if (o_mon_en) begin en_n++; if (en_first == 0) en_first = n; end
      if (o_busy !== 1'b1) busy_bad = 1;
      if (o_min_count !== pmin || o_min_idx !== pidx || o_lo_flags !== plo ||
          o_hi_flags !== phi || o_alarm !== palm) moved = 1;
      i_start = (n == 3);
      @(negedge i_clk);
      n++;
    end
    i_start = 1'b0;
    exp_meas = exp_meas + 16'd1;
    check({p, "_latency"}, 64'(n), 64'(wexp + S + NB + 2));
    check({p, "_clear_width"}, 64'(clr_n), 1);
    check({p, "_clear_cycle"}, 64'(clr_last), 1);
    check({p, "_en_width"}, 64'(en_n), 64'(wexp));
    check({p, "_en_start"}, 64'(en_first), 2);
    check({p, "_busy_during"}, 64'(busy_bad), 0);
    check({p, "_stable"}, 64'(moved), 0);
    check_results(p);
    check({p, "_meas"}, 64'(o_meas_cnt), 64'(exp_meas));
    check({p, "_target"}, 64'(o_mon_target), 64'(tgt));
    @(negedge i_clk);
    check({p, "_busy_after"}, 64'(o_busy), 0);
    check({p, "_done_pulse"}, 64'(o_done), 0);
  endtask

  initial begin
    int n;
    bit saw_done;
    logic [63:0] rm;
    tbl[0] = '{16'd100, 16'd1000, 16'd2000, '0, 16'd1500, 7, 16'd900, 7, 16'd900,
               16'd900, 7, NB'(1) << 7, '0};
    tbl[1] = '{16'd20, 16'd1000, 16'd2000, NB'(1) << 3, 16'd1500, 3, 16'd500, 9, 16'd500,
               16'd500, 9, NB'(1) << 9, '0};
    tbl[2] = '{16'd5, 16'd1000, 16'd2000, ALL, 16'd1500, 3, 16'd500, 9, 16'd500,
               16'hFFFF, 0, '0, '0};
    tbl[3] = '{16'd0, 16'd1000, 16'd2000, '0, 16'd1500, 0, 16'd2500, 29, 16'd100,
               16'd100, 29, NB'(1) << 29, NB'(1)};
    tbl[4] = '{16'd3, 16'd2000, 16'd1000, '0, 16'd1500, 5, 16'd1500, 6, 16'd1500,
               16'd1500, 0, ALL, ALL};
    tbl[5] = '{16'd1, 16'd1000, 16'd2000, '0, 16'd1500, 3, 16'd500, 9, 16'd500,
               16'd500, 3, (NB'(1) << 3) | (NB'(1) << 9), '0};
    tbl[6] = '{16'd2, 16'd1000, 16'd2000, NB'(1), 16'd1000, 4, 16'd2000, 0, 16'd50,
               16'd1000, 1, '0, '0};
    tbl[7] = '{16'd1, 16'd1000, 16'd2000, ALL ^ (NB'(1) << 29), 16'd1500, 29, 16'd2100, 0,
               16'd10, 16'd2100, 29, '0, NB'(1) << 29};

    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_cont = 1'b0; i_target = '0;
    i_window = '0; i_thr_lo = '0; i_thr_hi = '0; i_mask = '0;
    set_counts(16'd0, 0, 16'd0, 0, 16'd0);
    exp_meas = 16'd0;
    repeat (3) @(negedge i_clk);
    check_zero("reset");
    i_rst = 1'b0;
    @(negedge i_clk);
    check("idle_busy", 64'(o_busy), 0);

    for (int v = 0; v < 8; v++) begin
      set_counts(tbl[v].base, tbl[v].ia, tbl[v].va, tbl[v].ib, tbl[v].vb);
      run_meas($sformatf("vec%0d", v), tbl[v].window, tbl[v].lo, tbl[v].hi, tbl[v].mask,
               3'(v));
      check($sformatf("vec%0d_tbl_min", v), 64'(o_min_count), 64'(tbl[v].e_min));
      check($sformatf("vec%0d_tbl_idx", v), 64'(o_min_idx), 64'(tbl[v].e_idx));
      check($sformatf("vec%0d_tbl_lo", v), 64'(o_lo_flags), 64'(tbl[v].e_lo));
      check($sformatf("vec%0d_tbl_hi", v), 64'(o_hi_flags), 64'(tbl[v].e_hi));
    end

    // start together with stop in IDLE must not launch
    i_start = 1'b1; i_stop = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_stop = 1'b0;
    check("startstop_busy", 64'(o_busy), 0);
    check("startstop_clear", 64'(o_mon_clear), 0);
    @(negedge i_clk);
    check("startstop_busy2", 64'(o_busy), 0);

    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < NB; k++) cnt[k] = 16'($urandom_range(1, 40) * 100);
      pack_counts();
      rm = {$urandom, $urandom} & {$urandom, $urandom};
      if (r == 5) rm = '1;
      run_meas($sformatf("rnd%0d", r), 16'($urandom_range(0, 20)),
               16'($urandom_range(0, 4500)), 16'($urandom_range(0, 4500)), NB'(rm),
               3'($urandom));
    end

    // Continuous mode, stopped during the third scan
    set_counts(16'd1500, 2, 16'd800, 2, 16'd800);
    model(16'd1000, 16'd2000, '0);
    i_window = 16'd10; i_thr_lo = 16'd1000; i_thr_hi = 16'd2000; i_mask = '0;
    i_target = 3'd3; i_cont = 1'b1; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_cont = 1'b0; n = 1;
    while (o_done !== 1'b1 && n < 100) begin @(negedge i_clk); n++; end
    exp_meas = exp_meas + 16'd1;
    check("cont_done1", 64'(n), 46);
    check_results("cont_m1");
    check("cont_m1_meas", 64'(o_meas_cnt), 64'(exp_meas));
    set_counts(16'd1500, 5, 16'd700, 5, 16'd700);
    model(16'd1000, 16'd2000, '0);
    @(negedge i_clk);
    n++;
    check("cont_gap_busy", 64'(o_busy), 1);
    check("cont_gap_clear", 64'(o_mon_clear), 1);
    while (o_done !== 1'b1 && n < 200) begin @(negedge i_clk); n++; end
    exp_meas = exp_meas + 16'd1;
    check("cont_done2", 64'(n), 92);
    check_results("cont_m2");
    check("cont_m2_meas", 64'(o_meas_cnt), 64'(exp_meas));
    set_counts(16'd1500, 11, 16'd300, 11, 16'd300);
    while (n < 112) begin @(negedge i_clk); n++; end
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
    check("cont_stop_busy", 64'(o_busy), 0);
    check("cont_stop_done", 64'(o_done), 0);
    check_results("cont_stop");
    check("cont_stop_meas", 64'(o_meas_cnt), 64'(exp_meas));
    saw_done = 0;
    repeat (50) begin @(negedge i_clk); if (o_done === 1'b1) saw_done = 1; end
    check("cont_no_late_done", 64'(saw_done), 0);

    // Reset in the middle of RUN
    i_window = 16'd100; i_target = 3'd5; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    check("rst_mid_in_run", 64'(o_mon_en), 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_zero("rst_mid");
    i_rst = 1'b0;
    exp_meas = 16'd0;
    @(negedge i_clk);
    check("rst_mid_idle", 64'(o_busy), 0);

    // Measurement counter wrap
    force dut.meas_cnt_q = 16'hFFFF;
    @(negedge i_clk);
    release dut.meas_cnt_q;
    @(negedge i_clk);
    check("wrap_preload", 64'(o_meas_cnt), 64'hFFFF);
    exp_meas = 16'hFFFF;
    set_counts(16'd1500, 7, 16'd900, 7, 16'd900);
    run_meas("wrap", 16'd4, 16'd1000, 16'd2000, '0, 3'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
